half_duplex_bus_port: RTL and testbench

- Bidirectional half-duplex port on a shared tristate data bus. It is the receive-and-turnaround counterpart of the team's tristate driver.
- Listens (bus released, hi-Z) by default and captures words the peer strobes onto the bus.
- On a local transmit request with bus grant, performs a guarded turnaround, drives a burst of words, then releases the bus through a second turnaround.
- Sits between the core datapath (valid/ready tx, valid-only rx) and the board-level shared bus.

---
 rtl/half_duplex_pkg.sv | 16 +
 rtl/half_duplex_bus_port_drv.sv | 13 +
 rtl/half_duplex_bus_port.sv | 128 ++++++++++++
 tb/tb_half_duplex_bus_port.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/half_duplex_pkg.sv
// Shared types and helpers for the half-duplex bus port.
// State encoding plus turnaround counter sizing.
package half_duplex_pkg;

  typedef enum logic [1:0] {
    LISTEN   = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } hd_state_e;

  function automatic int cnt_w(input int turn_cyc);
    return $clog2(turn_cyc + 1);
  endfunction

endpackage

// File: rtl/half_duplex_bus_port_drv.sv
// Pure tristate driver for the shared data bus.
// dq follows d while oe is high, otherwise released to hi-Z.
module bus_tri_drv #(
  parameter int DATA_W = 8
) (
  input  logic              oe,
  input  logic [DATA_W-1:0] d,
  inout  wire  [DATA_W-1:0] dq
);

  assign dq = oe ? d : {DATA_W{1'bz}};

endmodule

// File: rtl/half_duplex_bus_port.sv
// Half-duplex port: listen by default, guarded turnaround to drive bursts.
// Optional sticky contention flag under HALF_DUPLEX_CONTENTION_CHK_EN.
module half_duplex_bus_port
  import half_duplex_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  inout  wire  [DATA_W-1:0] bus_dq,
  output logic              bus_oe,
  output logic              bus_stb_o,
  input  logic              bus_stb_i,
  input  logic              bus_gnt
`ifdef HALF_DUPLEX_CONTENTION_CHK_EN
  ,
  output logic              err_contention
`endif
);

  localparam int CW = cnt_w(TURN_CYC);
  localparam logic [CW-1:0] LAST = CW'(TURN_CYC - 1);

  hd_state_e         state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] drv_q;
  logic              listening;

  assign tx_ready  = (state == DRIVE) && bus_gnt;
  assign listening = (state == LISTEN) || (state == TURN_ON);

  // Turnaround / burst FSM with registered bus_oe and strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LISTEN;
      cnt       <= '0;
      drv_q     <= '0;
      bus_oe    <= 1'b0;
      bus_stb_o <= 1'b0;
    end else begin
      bus_stb_o <= 1'b0;
      unique case (state)
        LISTEN: begin
          if (tx_valid && bus_gnt) begin
            state <= TURN_ON;
            cnt   <= '0;
          end
        end
        TURN_ON: begin
          if (!tx_valid || !bus_gnt) begin
            state <= LISTEN;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state  <= DRIVE;
            cnt    <= '0;
            bus_oe <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRIVE: begin
          if (tx_valid && tx_ready) begin
            drv_q     <= tx_data;
            bus_stb_o <= 1'b1;
          end else begin
            state  <= TURN_OFF;
            cnt    <= '0;
            bus_oe <= 1'b0;
          end
        end
        TURN_OFF: begin
          if (cnt == LAST) begin
            state <= LISTEN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= LISTEN;
          cnt    <= '0;
          bus_oe <= 1'b0;
        end
      endcase
    end
  end

  // Capture peer words while the bus is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (bus_stb_i && listening) begin
        rx_valid <= 1'b1;
        rx_data  <= bus_dq;
      end
    end
  end

`ifdef HALF_DUPLEX_CONTENTION_CHK_EN
  // Sticky flag: peer strobing while we own the bus, or strobing without grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_contention <= 1'b0;
    end else if ((bus_stb_i && !listening) ||
                 ((state == DRIVE) && !bus_gnt && bus_stb_o)) begin
      err_contention <= 1'b1;
    end
  end
`endif

  bus_tri_drv #(
    .DATA_W (DATA_W)
  ) u_drv (
    .oe (bus_oe),
    .d  (drv_q),
    .dq (bus_dq)
  );

endmodule

// File: tb/tb_half_duplex_bus_port.sv
// Scoreboard bench for half_duplex_bus_port (TURN_CYC=1 and TURN_CYC=3).
// Monitor pops expected rx words and strobed tx words as they appear.
module tb_half_duplex_bus_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid, tx_ready, rx_valid;
  logic [7:0] tx_data, rx_data;
  wire  [7:0] bus_dq;
  logic       bus_oe, bus_stb_o, bus_stb_i, bus_gnt;
  logic       peer_oe;
  logic [7:0] peer_d;

  logic       tx3_valid, tx3_ready, rx3_valid, bus3_oe;
  logic       bus3_stb_o, gnt3;
  logic [7:0] rx3_data;
  wire  [7:0] bus3_dq;

`ifdef HALF_DUPLEX_CONTENTION_CHK_EN
  logic err_contention, err3;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  assign bus_dq = peer_oe ? peer_d : 8'hzz;

  always #5 clk = ~clk;

  half_duplex_bus_port #(.DATA_W(8), .TURN_CYC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .bus_dq    (bus_dq),
    .bus_oe    (bus_oe),
    .bus_stb_o (bus_stb_o),
    .bus_stb_i (bus_stb_i),
    .bus_gnt   (bus_gnt)
`ifdef HALF_DUPLEX_CONTENTION_CHK_EN
    ,
    .err_contention (err_contention)
`endif
  );

  half_duplex_bus_port #(.DATA_W(8), .TURN_CYC(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx3_valid),
    .tx_data   (8'h99),
    .tx_ready  (tx3_ready),
    .rx_valid  (rx3_valid),
    .rx_data   (rx3_data),
    .bus_dq    (bus3_dq),
    .bus_oe    (bus3_oe),
    .bus_stb_o (bus3_stb_o),
    .bus_stb_i (1'b0),
    .bus_gnt   (gnt3)
`ifdef HALF_DUPLEX_CONTENTION_CHK_EN
    ,
    .err_contention (err3)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rx pulse and every tx strobe must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid) begin
        n_cmp++;
        if (rx_q.size() == 0) begin
          n_bad++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_data);
        end else begin
          logic [7:0] e;
          e = rx_q.pop_front();
          if (rx_data !== e) begin
            n_bad++;
            $display("FAIL rx_data: got %0h expected %0h", rx_data, e);
          end
        end
      end
      if (bus_stb_o) begin
        n_cmp++;
        if (tx_q.size() == 0) begin
          n_bad++;
          $display("FAIL tx_unexpected: got %0h expected none", bus_dq);
        end else begin
          logic [7:0] e;
          e = tx_q.pop_front();
          if (bus_dq !== e || bus_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_word: got %0h oe=%0b expected %0h oe=1",
                     bus_dq, bus_oe, e);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; tx_valid = 0; tx_data = 0; bus_stb_i = 0; bus_gnt = 0;
    peer_oe = 0; peer_d = 0; tx3_valid = 0; gnt3 = 0;
    tick(); tick();
    chk("rst_oe", 32'(bus_oe), 0);
    chk("rst_stb", 32'(bus_stb_o), 0);
    chk("rst_rdy", 32'(tx_ready), 0);
    chk("rst_rxv", 32'(rx_valid), 0);
    chk("rst_rxd", 32'(rx_data), 0);
`ifdef HALF_DUPLEX_CONTENTION_CHK_EN
    chk("rst_err", 32'(err_contention), 0);
`endif
    rst_n = 1'b1;
    tick();

    // Back-to-back peer strobes in LISTEN.
    peer_oe = 1; peer_d = 8'hA5; bus_stb_i = 1; rx_q.push_back(8'hA5);
    tick();
    chk("rx1_v", 32'(rx_valid), 1);
    chk("rx1_d", 32'(rx_data), 32'hA5);
    peer_d = 8'h3C; rx_q.push_back(8'h3C);
    tick();
    chk("rx2_v", 32'(rx_valid), 1);
    chk("rx2_d", 32'(rx_data), 32'h3C);
    peer_oe = 0; bus_stb_i = 0;
    tick();
    chk("rx_hold_v", 32'(rx_valid), 0);
    chk("rx_hold_d", 32'(rx_data), 32'h3C);

    // Full burst 11,22,33 with TURN_CYC=1.
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
    bus_gnt = 1; tx_valid = 1; tx_data = 8'h11;
    tick();
    chk("b_on_oe", 32'(bus_oe), 0);
    chk("b_on_rdy", 32'(tx_ready), 0);
    tick();
    chk("b_drv_oe", 32'(bus_oe), 1);
    chk("b_drv_stb", 32'(bus_stb_o), 0);
    chk("b_drv_rdy", 32'(tx_ready), 1);
    tick(); tx_data = 8'h22;
    tick(); tx_data = 8'h33;
    tick(); tx_valid = 0;
    #1;
    chk("b_last_stb", 32'(bus_stb_o), 1);
    chk("b_last_oe", 32'(bus_oe), 1);
    tick();
    chk("b_off_oe", 32'(bus_oe), 0);
    chk("b_off_rdy", 32'(tx_ready), 0);
    peer_oe = 1; peer_d = 8'h5A; bus_stb_i = 1;
    tick();
    chk("b_ign_rxv", 32'(rx_valid), 0);
    peer_d = 8'h77; rx_q.push_back(8'h77);
    tick();
    chk("b_lis_rxv", 32'(rx_valid), 1);
    peer_oe = 0; bus_stb_i = 0;
    tick();

    // Grant drops after 0x22 is accepted.
    tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    tx_valid = 1; tx_data = 8'h11;
    tick(); tick();
    chk("g_drv_oe", 32'(bus_oe), 1);
    tick(); tx_data = 8'h22;
    tick(); tx_data = 8'h33; bus_gnt = 0;
    #1;
    chk("g_rdy", 32'(tx_ready), 0);
    chk("g_stb", 32'(bus_stb_o), 1);
    tick();
    chk("g_rel_oe", 32'(bus_oe), 0);
    tx_valid = 0;
    tick(); tick();

    // Reset while driving releases the bus at that edge.
    bus_gnt = 1; tx_valid = 1; tx_data = 8'hEE;
    tick(); tick();
    chk("r_drv_oe", 32'(bus_oe), 1);
    rst_n = 0;
    tick();
    chk("r_oe", 32'(bus_oe), 0);
    chk("r_rxv", 32'(rx_valid), 0);
    chk("r_rxd", 32'(rx_data), 0);
    chk("r_stb", 32'(bus_stb_o), 0);
    rst_n = 1; tx_valid = 0;
    peer_oe = 1; peer_d = 8'h42; bus_stb_i = 1; rx_q.push_back(8'h42);
    tick();
    chk("r_lis_rxv", 32'(rx_valid), 1);
    peer_oe = 0; bus_stb_i = 0;
    tick();

    // TURN_CYC=3: abort in second TURN_ON cycle, then a clean entry.
    tx3_valid = 1; gnt3 = 1;
    tick();
    chk("a_oe1", 32'(bus3_oe), 0);
    tick(); gnt3 = 0;
    #1;
    chk("a_rdy", 32'(tx3_ready), 0);
    tick(); tx3_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("a_oe_idle", 32'(bus3_oe), 0);
      chk("a_rdy_idle", 32'(tx3_ready), 0);
      tick();
    end
    tx3_valid = 1; gnt3 = 1;
    tick(); tick(); tick();
    chk("a_oe_pre", 32'(bus3_oe), 0);
    tick();
    chk("a_oe_on", 32'(bus3_oe), 1);
    chk("a_rdy_on", 32'(tx3_ready), 1);
    tx3_valid = 0;
    tick();
    chk("a_oe_off", 32'(bus3_oe), 0);
    tick(); tick(); tick();

`ifdef HALF_DUPLEX_CONTENTION_CHK_EN
    // Peer strobe during DRIVE sets a sticky error, no rx pulse.
    tx_q.push_back(8'h11);
    tx_valid = 1; tx_data = 8'h11;
    tick(); tick();
    bus_stb_i = 1;
    tick();
    chk("c_err", 32'(err_contention), 1);
    chk("c_rxv", 32'(rx_valid), 0);
    bus_stb_i = 0; tx_valid = 0;
    tick(); tick(); tick();
    chk("c_sticky", 32'(err_contention), 1);
    rst_n = 0;
    tick();
    chk("c_clr", 32'(err_contention), 0);
    rst_n = 1;
    tick();
`endif

    tick();
    chk("rx_q_empty", 32'(rx_q.size()), 0);
    chk("tx_q_empty", 32'(tx_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
